// File: rtl/stopwatch_counter.sv
// Stopwatch: 0.1 s prescaler, BCD M:SS.T count, lap snapshot.
// Buttons arrive synchronised and debounced; rising edges drive the FSM.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap_reset,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       running,
  output logic       lap_active
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP,
    LAP
  } state_t;

  state_t state_q, state_d;

  logic ss_q, lr_q;
  logic ss_arm_q, lr_arm_q;
  logic ss_edge, lr_edge;

  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   live_q, live_d;
  logic [15:0]   snap_q, snap_d;
  logic [15:0]   live_inc;

  logic counting, tick;
  logic go_lap, go_idle;

  // Arm flags block edges from a button already held through reset
  assign ss_edge = start_stop & ~ss_q & ss_arm_q;
  assign lr_edge = lap_reset & ~lr_q & lr_arm_q;

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (pre_q == PMAX);

  // Button history registers for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q     <= 1'b0;
      lr_q     <= 1'b0;
      ss_arm_q <= 1'b0;
      lr_arm_q <= 1'b0;
    end else begin
      ss_q     <= start_stop;
      lr_q     <= lap_reset;
      ss_arm_q <= ss_arm_q | ~start_stop;
      lr_arm_q <= lr_arm_q | ~lap_reset;
    end
  end

  // Next state; start_stop wins over a simultaneous lap_reset
  always_comb begin
    state_d = state_q;
    go_lap  = 1'b0;
    go_idle = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_edge) state_d = RUN;
      end
      RUN: begin
        if (ss_edge) begin
          state_d = STOP;
        end else if (lr_edge) begin
          state_d = LAP;
          go_lap  = 1'b1;
        end
      end
      STOP: begin
        if (ss_edge) begin
          state_d = RUN;
        end else if (lr_edge) begin
          state_d = IDLE;
          go_idle = 1'b1;
        end
      end
      LAP: begin
        if (ss_edge) state_d = STOP;
        else if (lr_edge) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // BCD +0.1 s with 9:59.9 wrapping to 0:00.0
  always_comb begin
    live_inc = live_q;
    if (live_q[3:0] != 4'd9) begin
      live_inc[3:0] = live_q[3:0] + 4'd1;
    end else begin
      live_inc[3:0] = 4'd0;
      if (live_q[7:4] != 4'd9) begin
        live_inc[7:4] = live_q[7:4] + 4'd1;
      end else begin
        live_inc[7:4] = 4'd0;
        if (live_q[11:8] != 4'd5) begin
          live_inc[11:8] = live_q[11:8] + 4'd1;
        end else begin
          live_inc[11:8] = 4'd0;
          if (live_q[15:12] != 4'd9)
            live_inc[15:12] = live_q[15:12] + 4'd1;
          else
            live_inc[15:12] = 4'd0;
        end
      end
    end
  end

  // Datapath next values: prescaler holds in STOP, all clear on return to IDLE
  always_comb begin
    pre_d  = pre_q;
    live_d = live_q;
    snap_d = snap_q;
    if (go_idle) begin
      pre_d  = '0;
      live_d = '0;
      snap_d = '0;
    end else begin
      if (tick) pre_d = '0;
      else if (counting) pre_d = pre_q + 1'b1;
      if (tick) live_d = live_inc;
      if (go_lap) snap_d = live_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      live_q  <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      live_q  <= live_d;
      snap_q  <= snap_d;
    end
  end

  assign {digit3, digit2, digit1, digit0} =
    (state_q == LAP) ? snap_q : live_q;

  assign running    = counting;
  assign lap_active = (state_q == LAP);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter with TICK_DIV = 4.
// Expected displays are queued at stimulus time and popped at sample time.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       lap_reset = 1'b0;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       running, lap_active;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  logic [17:0] e;

  stopwatch_counter #(.TICK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .start_stop(start_stop),
    .lap_reset(lap_reset),
    .digit3(digit3),
    .digit2(digit2),
    .digit1(digit1),
    .digit0(digit0),
    .running(running),
    .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  // Expected {d3,d2,d1,d0,running,lap_active} from a tenths count
  function automatic logic [17:0] expv(input int t, input logic r,
                                       input logic l);
    int m;
    m = t % 6000;
    return {4'(m / 600), 4'((m % 600) / 100), 4'((m % 100) / 10),
            4'(m % 10), r, l};
  endfunction

  function automatic logic [17:0] obs();
    return {digit3, digit2, digit1, digit0, running, lap_active};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start_stop = 1'b0;
    lap_reset = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; button high across exactly one posedge
  task automatic press(input logic ss, input logic lr);
    start_stop = ss;
    lap_reset = lr;
    @(posedge clk);
    @(negedge clk);
    start_stop = 1'b0;
    lap_reset = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_q.push_back(expv(0, 0, 0));
    exp_q.push_back(expv(0, 0, 0));
    repeat (2) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_hold got=%h exp=%h", obs(), e);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_idle got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_run();
    do_reset();
    press(1, 0);
    exp_q.push_back(expv(5, 1, 0));
    exp_q.push_back(expv(10, 1, 0));
    repeat (20) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL run_half got=%h exp=%h", obs(), e);
    end
    repeat (20) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL run_1s got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    press(1, 0);
    exp_q.push_back(expv(5998, 1, 0));
    exp_q.push_back(expv(5999, 1, 0));
    exp_q.push_back(expv(0, 1, 0));
    for (int k = 1; k <= 24000; k++) begin
      @(negedge clk);
      checks++;
      if (digit0 > 4'd9 || digit1 > 4'd9 || digit2 > 4'd5 ||
          digit3 > 4'd9) begin
        errors++; $display("FAIL bcd_valid got=%h exp=legal", obs());
      end
      if (k == 23992 || k == 23996 || k == 24000) begin
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL wrap_k%0d got=%h exp=%h", k, obs(), e);
        end
      end
    end
  endtask

  task automatic test_lap();
    do_reset();
    press(1, 0);
    repeat (92) @(negedge clk);
    press(0, 1);
    exp_q.push_back(expv(23, 1, 1));
    exp_q.push_back(expv(23, 1, 1));
    exp_q.push_back(expv(28, 1, 0));
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL lap_enter got=%h exp=%h", obs(), e);
    end
    repeat (20) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL lap_frozen got=%h exp=%h", obs(), e);
    end
    press(0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL lap_exit got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_lap_tick();
    do_reset();
    press(1, 0);
    repeat (19) @(negedge clk);
    press(0, 1);
    exp_q.push_back(expv(4, 1, 1));
    exp_q.push_back(expv(4, 1, 1));
    exp_q.push_back(expv(5, 1, 0));
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL lap_tick_snap got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL lap_tick_hold got=%h exp=%h", obs(), e);
    end
    press(0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL lap_tick_live got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_both_edges();
    do_reset();
    press(1, 0);
    repeat (8) @(negedge clk);
    press(1, 1);
    exp_q.push_back(expv(2, 0, 0));
    exp_q.push_back(expv(2, 0, 0));
    exp_q.push_back(expv(0, 0, 0));
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL both_stop got=%h exp=%h", obs(), e);
    end
    repeat (8) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL both_held got=%h exp=%h", obs(), e);
    end
    press(0, 1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL stop_to_idle got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_resume_phase();
    do_reset();
    press(1, 0);
    repeat (5) @(negedge clk);
    press(1, 0);
    exp_q.push_back(expv(1, 0, 0));
    exp_q.push_back(expv(1, 1, 0));
    exp_q.push_back(expv(2, 1, 0));
    repeat (4) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL stop_hold got=%h exp=%h", obs(), e);
    end
    press(1, 0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL resume_pre got=%h exp=%h", obs(), e);
    end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL resume_tick got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    press(1, 0);
    repeat (12) @(negedge clk);
    press(0, 1);
    exp_q.push_back(expv(3, 1, 1));
    exp_q.push_back(expv(0, 0, 0));
    exp_q.push_back(expv(0, 0, 0));
    exp_q.push_back(expv(0, 0, 0));
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL async_pre got=%h exp=%h", obs(), e);
    end
    #2 rst = 1'b1;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL async_now got=%h exp=%h", obs(), e);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL async_after got=%h exp=%h", obs(), e);
    end
    repeat (8) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL async_idle got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_held_button();
    rst = 1'b1;
    start_stop = 1'b1;
    lap_reset = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(expv(0, 0, 0));
    exp_q.push_back(expv(0, 1, 0));
    repeat (6) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL held_no_edge got=%h exp=%h", obs(), e);
    end
    start_stop = 1'b0;
    @(negedge clk);
    press(1, 0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL held_rearm got=%h exp=%h", obs(), e);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_lap();
    test_lap_tick();
    test_both_edges();
    test_resume_phase();
    test_async_reset();
    test_held_button();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5000000, meaning clk cycles per 0.1 s tick (50 MHz clock); legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_stop  input  1  level from synchronised, debounced button; action on rising edge.
REQ-005 SHALL have port lap_reset  input  1  level from synchronised, debounced button; action on rising edge.
REQ-006 SHALL have port digit3  output  4  BCD minutes, 0-9.
REQ-007 SHALL have port digit2  output  4  BCD tens of seconds, 0-5.
REQ-008 SHALL have port digit1  output  4  BCD seconds, 0-9.
REQ-009 SHALL have port digit0  output  4  BCD tenths, 0-9.
REQ-010 SHALL have port running  output  1  high in RUN or LAP.
REQ-011 SHALL have port lap_active  output  1  high in LAP.

Function
REQ-012 SHALL detect edges by registering each button once; edge = input high AND previous sample low; the action takes effect on the next rising clk.
REQ-013 SHALL implement states IDLE, RUN, STOP, LAP.
REQ-014 SHALL transition: IDLE + start_stop -> RUN; RUN + start_stop -> STOP; STOP + start_stop -> RUN; RUN + lap_reset -> LAP; LAP + lap_reset -> RUN; LAP + start_stop -> STOP; STOP + lap_reset -> IDLE; all other combinations leave the state unchanged.
REQ-015 SHALL, when both edges occur in the same cycle, act on start_stop only and discard lap_reset.
REQ-016 SHALL use a prescaler counting 0..TICK_DIV-1 only in RUN or LAP, and generate a one-cycle tick when it equals TICK_DIV-1 and then wraps to 0.
REQ-017 SHALL hold the prescaler value in STOP, so a resume keeps the sub-tick phase, and clear it to 0 on entry to IDLE.
REQ-018 SHALL increment the live BCD count by 0.1 s on each tick, with the update visible the cycle after the tick.
REQ-019 SHALL carry the count as: tenths 9->0 carries to seconds; seconds 9->0 carries to tens; tens 5->0 carries to minutes; minutes 9->0 with all digits zero (9:59.9 -> 0:00.0 wrap, no flag).
REQ-020 SHALL never let any digit take a non-BCD value or let digit2 exceed 5.
REQ-021 SHALL, on the RUN->LAP transition, capture the live count as it stands in the same cycle as the edge into a snapshot register; a tick in that same cycle is excluded from the snapshot but still applied to the live count.
REQ-022 SHALL drive digit3..0 from the snapshot in LAP and from the live count in all other states.
REQ-023 SHALL keep the live count running during LAP, so that on LAP->RUN the display jumps to the live value.
REQ-024 SHALL clear the live count, snapshot and prescaler to zero on the STOP->IDLE transition.
REQ-025 SHALL drive running and lap_active combinationally from the state register.

Reset
REQ-026 SHALL, while rst is high, force state IDLE, live count and snapshot 0:00.0, prescaler 0 and edge registers 0; outputs read digit3..0 = 0, running = 0, lap_active = 0.
REQ-027 SHALL respond to rst asserted mid-RUN or mid-LAP immediately (asynchronously) with no pending action surviving.
REQ-028 SHALL, after rst deasserts with a button already held high, not register an edge until the button goes low and then high again.

Verification (TICK_DIV = 4)
REQ-029 SHALL check: reset, start_stop pulse, 40 clk -> 10 ticks, display 0:01.0, running = 1.
REQ-030 SHALL check: preload 9:59.8 via run time, two ticks -> 9:59.9 then 0:00.0, all digits valid throughout.
REQ-031 SHALL check: RUN at 0:02.3, lap_reset -> display frozen at 0:02.3, lap_active = 1; after 20 clk, lap_reset -> display shows 0:02.8.
REQ-032 SHALL check: start_stop and lap_reset rising in the same cycle during RUN -> STOP, lap_active = 0, count held; a further lap_reset -> IDLE, 0:00.0.
REQ-033 SHALL check: stop 2 clk after a tick, resume -> next tick arrives exactly 2 clk after resume (prescaler phase held).
REQ-034 SHALL check: rst pulsed mid-LAP between clock edges -> outputs go to 0 before the next clk edge, state IDLE.
